// File: rtl/gf2_poly_div_seq.sv
// rtl/gf2_poly_div_seq.sv - bit-serial GF(2)[x] long divider: a = q*b ^ r, deg r < deg b.
// The divisor is first normalised so its top bit is set; the remainder is shifted back at the output.
module gf2_poly_div_seq #(
  parameter int DW = 16,
  parameter int NW = 2*DW-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          div0
);

  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(NW+DW);

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t        state, state_nx;
  logic [NW-1:0] dsr;
  logic [DW-1:0] bn;
  logic [DW-2:0] w;
  logic [SW-1:0] s;
  logic [CW-1:0] cnt;
  logic [NW-1:0] q_reg;
  logic          div0_reg;
  logic [DW-1:0] t;
  logic [DW-2:0] w_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (b == '0) ? DONE : NORM;
      NORM:    if (bn[DW-1]) state_nx = DIV;
      DIV:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One long-division step: bring in the next dividend bit, subtract bn if the top bit is set.
  always_comb begin
    t    = {w, dsr[NW-1]};
    w_nx = t[DW-1] ? (t[DW-2:0] ^ bn[DW-2:0]) : t[DW-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsr      <= '0;
      bn       <= '0;
      w        <= '0;
      s        <= '0;
      cnt      <= '0;
      q_reg    <= '0;
      div0_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr      <= a;
            bn       <= b;
            w        <= '0;
            s        <= '0;
            q_reg    <= '0;
            div0_reg <= (b == '0);
          end
        end
        NORM: begin
          if (!bn[DW-1]) begin
            bn <= bn << 1;
            s  <= s + SW'(1);
          end else begin
            cnt <= CW'(NW) + CW'(s);
          end
        end
        DIV: begin
          // Shifting zeros in from the right supplies the s trailing zero bits.
          dsr   <= dsr << 1;
          w     <= w_nx;
          q_reg <= {q_reg[NW-2:0], t[DW-1]};
          cnt   <= cnt - CW'(1);
        end
        DONE: begin
          if (out_ready) div0_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q         = q_reg;
  assign r         = {1'b0, w} >> s;
  assign div0      = div0_reg;

endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// tb/tb_gf2_poly_div_seq.sv - randomized self-checking bench for gf2_poly_div_seq against a textbook division model.
module tb_gf2_poly_div_seq;

  localparam int DW = 16;
  localparam int NW = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] q;
  logic [DW-1:0] r;
  logic          div0;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  gf2_poly_div_seq #(.DW(DW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r), .div0(div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int deg_of(input logic [DW-1:0] p);
    int d = -1;
    for (int i = 0; i < DW; i++) if (p[i]) d = i;
    return d;
  endfunction

  // Schoolbook polynomial long division over GF(2), highest degree first.
  function automatic void model(input logic [NW-1:0] aa, input logic [DW-1:0] bb,
                                output logic [NW-1:0] qq, output logic [DW-1:0] rr,
                                output logic d0, output int lat);
    int db;
    logic [NW-1:0] rem;
    qq = '0;
    rr = '0;
    d0 = 1'b0;
    db = deg_of(bb);
    if (db < 0) begin
      d0 = 1'b1;
      lat = 1;
      return;
    end
    rem = aa;
    for (int i = NW-1; i >= db; i--) begin
      if (rem[i]) begin
        rem ^= NW'(bb) << (i - db);
        qq[i - db] = 1'b1;
      end
    end
    rr = rem[DW-1:0];
    lat = NW + 2*(DW-1-db) + 2;
  endfunction

  function automatic logic [NW-1:0] clmul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [NW-1:0] p = '0;
    for (int i = 0; i < DW; i++) if (y[i]) p ^= NW'(x) << i;
    return p;
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  logic          have_exp = 1'b0;
  logic          first = 1'b0;
  int            acc_cyc = 0;
  int            e_lat = 0;
  logic [NW-1:0] e_q;
  logic [DW-1:0] e_r;
  logic          e_d0;

  always @(negedge clk) begin
    if (rst) begin
      have_exp = 1'b0;
    end else begin
      if (out_valid) begin
        chk("out_valid_expected", have_exp, 1);
        if (have_exp) begin
          if (first) begin
            chk("latency", cyc - acc_cyc + 1, e_lat);
            first = 1'b0;
          end
          chk("q", q, e_q);
          chk("r", r, e_r);
          chk("div0", div0, e_d0);
          chk("in_ready_in_done", in_ready, 0);
        end
      end
      if (in_valid && in_ready) begin
        model(a, b, e_q, e_r, e_d0, e_lat);
        have_exp = 1'b1;
        first = 1'b1;
        acc_cyc = cyc + 1;
      end
    end
  end

  task automatic run_op(input logic [NW-1:0] aa, input logic [DW-1:0] bb, input int hold,
                        output logic [NW-1:0] qo, output logic [DW-1:0] ro,
                        output logic d0, output int lat);
    int guard = 0;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = NW'($urandom);
    b = DW'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_wait", out_valid, 1);
    in_valid = (hold > 0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    qo = q;
    ro = r;
    d0 = div0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] qo, mq;
    logic [DW-1:0] ro, mr;
    logic          d0, md0;
    int            lat, mlat;
    logic [DW-1:0] x, y, r0;
    int            k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_div0", div0, 0);
    rst = 1'b0;

    model(31'h5, 16'h3, mq, mr, md0, mlat);
    chk("model_5_3_q", mq, 31'h3);
    chk("model_5_3_r", mr, 16'h0);
    model(31'h7, 16'h3, mq, mr, md0, mlat);
    chk("model_7_3_q", mq, 31'h2);
    chk("model_7_3_r", mr, 16'h1);

    run_op(31'h5, 16'h3, 0, qo, ro, d0, lat);
    chk("d53_q", qo, 31'h3);
    chk("d53_r", ro, 16'h0);
    chk("d53_lat", lat, 61);
    run_op(31'h7, 16'h3, 0, qo, ro, d0, lat);
    chk("d73_q", qo, 31'h2);
    chk("d73_r", ro, 16'h1);
    run_op(31'h7FFFFFFF, 16'h8000, 10, qo, ro, d0, lat);
    chk("dmax_q", qo, 31'hFFFF);
    chk("dmax_r", ro, 16'h7FFF);
    chk("dmax_lat", lat, 33);
    run_op(31'h12345678, 16'h0001, 0, qo, ro, d0, lat);
    chk("d1_q", qo, 31'h12345678);
    chk("d1_r", ro, 16'h0);
    chk("d1_lat", lat, 63);
    run_op(31'h12345678, 16'h0000, 3, qo, ro, d0, lat);
    chk("d0_flag", d0, 1);
    chk("d0_q", qo, 31'h0);
    chk("d0_r", ro, 16'h0);
    chk("d0_lat", lat, 1);
    #1;
    chk("d0_dropped", div0, 0);

    // Abort an operation five cycles into the division steps.
    in_valid = 1'b1;
    a = 31'h12345678;
    b = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (21) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    run_op(31'h0ABCDEF1, 16'h0123, 1, qo, ro, d0, lat);
    model(31'h0ABCDEF1, 16'h0123, mq, mr, md0, mlat);
    chk("after_abort_q", qo, mq);
    chk("after_abort_r", ro, mr);

    for (int n = 0; n < 1200; n++) begin
      k = $urandom_range(1, 16);
      y = DW'($urandom) & DW'((32'h1 << k) - 1);
      if (y == '0) y = 16'h1;
      x = DW'($urandom);
      r0 = DW'($urandom) & DW'((32'h1 << deg_of(y)) - 1);
      if ($urandom_range(0, 49) == 0) begin
        run_op(clmul(x, y) ^ NW'(r0), 16'h0, $urandom_range(0, 2), qo, ro, d0, lat);
        chk("rand_div0", d0, 1);
      end else begin
        run_op(clmul(x, y) ^ NW'(r0), y, $urandom_range(0, 2), qo, ro, d0, lat);
        chk("rand_q", qo, NW'(x));
        chk("rand_r", ro, r0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
